hazard_unit_md: RTL and testbench

Parametrised successor to the pipeline hazard unit for the 5-stage MIPS datapath. Adds decode-stage forwarding, execute-stage forwarding, and load-use and branch stall detection for any register-file size. Adds tracking for a non-stalling multi-cycle multiply/divide unit (MDU) and a saturating stall-cycle performance counter. Sits beside the datapath and drives the F/D stall enables and the E flush.

---
 rtl/hazard_unit_md_if.sv | 51 +++++
 rtl/hazard_unit_md.sv | 127 ++++++++++++
 tb/tb_hazard_unit_md.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_md_if.sv
// Hazard-unit bundle: datapath-side register numbers and control bits in,
// forwarding selects, pipeline stall/flush and MDU tracking status out.
interface hazard_unit_md_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs_d;
    logic [REG_AW-1:0] rt_d;
    logic [REG_AW-1:0] rs_e;
    logic [REG_AW-1:0] rt_e;
    logic [REG_AW-1:0] writereg_e;
    logic [REG_AW-1:0] writereg_m;
    logic [REG_AW-1:0] writereg_w;
    logic              memtoreg_e;
    logic              memtoreg_m;
    logic              regwrite_e;
    logic              regwrite_m;
    logic              regwrite_w;
    logic              branch_d;
    logic              md_op_d;
    logic              md_start_e;
    logic              stall_cnt_clr;

    logic              forwarda_d;
    logic              forwardb_d;
    logic [1:0]        forwarda_e;
    logic [1:0]        forwardb_e;
    logic              stall_f;
    logic              stall_d;
    logic              flush_e;
    logic              md_busy;
    logic              md_done;
    logic [REG_AW-1:0] md_dest;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
        output memtoreg_e, memtoreg_m, regwrite_e, regwrite_m, regwrite_w,
        output branch_d, md_op_d, md_start_e, stall_cnt_clr,
        input  forwarda_d, forwardb_d, forwarda_e, forwardb_e,
        input  stall_f, stall_d, flush_e, md_busy, md_done, md_dest, stall_cnt
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
        input  memtoreg_e, memtoreg_m, regwrite_e, regwrite_m, regwrite_w,
        input  branch_d, md_op_d, md_start_e, stall_cnt_clr,
        output forwarda_d, forwardb_d, forwarda_e, forwardb_e,
        output stall_f, stall_d, flush_e, md_busy, md_done, md_dest, stall_cnt
    );
endinterface

// File: rtl/hazard_unit_md.sv
// Hazard unit for the 5-stage MIPS pipeline: D/E forwarding, load-use, branch
// and MDU stalls, MDU in-flight tracking and a saturating stall-cycle counter.
module hazard_unit_md #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input logic             clk,
    input logic             reset,
    hazard_unit_md_if.slave hif
);
    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    localparam logic [3:0] MD_RELOAD = 4'(MD_LAT - 1);

    md_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [REG_AW-1:0] md_dest_q, md_dest_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic md_done;
    logic md_inflight;
    logic lwstall, branchstall, mdstall, stall;
    logic rd_e_hit, rd_m_hit, md_dest_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            md_dest_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_dest_q   <= md_dest_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        hif.forwarda_d = (hif.rs_d != '0) && (hif.rs_d == hif.writereg_m) && hif.regwrite_m;
        hif.forwardb_d = (hif.rt_d != '0) && (hif.rt_d == hif.writereg_m) && hif.regwrite_m;

        hif.forwarda_e = 2'b00;
        if ((hif.rs_e != '0) && (hif.rs_e == hif.writereg_m) && hif.regwrite_m)
            hif.forwarda_e = 2'b10;
        else if ((hif.rs_e != '0) && (hif.rs_e == hif.writereg_w) && hif.regwrite_w)
            hif.forwarda_e = 2'b01;

        hif.forwardb_e = 2'b00;
        if ((hif.rt_e != '0) && (hif.rt_e == hif.writereg_m) && hif.regwrite_m)
            hif.forwardb_e = 2'b10;
        else if ((hif.rt_e != '0) && (hif.rt_e == hif.writereg_w) && hif.regwrite_w)
            hif.forwardb_e = 2'b01;
    end

    // A reader in the md_done cycle is safe: the MDU write lands in the first
    // half-cycle and the register file read happens in the second.
    always_comb begin
        md_done     = (state_q == MD_BUSY) && (cnt_q == 4'd0);
        md_inflight = (state_q == MD_BUSY) && !md_done;

        rd_e_hit    = (hif.writereg_e != '0) &&
                      ((hif.writereg_e == hif.rs_d) || (hif.writereg_e == hif.rt_d));
        rd_m_hit    = (hif.writereg_m != '0) &&
                      ((hif.writereg_m == hif.rs_d) || (hif.writereg_m == hif.rt_d));
        md_dest_hit = (md_dest_q != '0) &&
                      ((md_dest_q == hif.rs_d) || (md_dest_q == hif.rt_d));

        lwstall     = hif.memtoreg_e && (hif.rt_e != '0) &&
                      ((hif.rt_e == hif.rs_d) || (hif.rt_e == hif.rt_d));
        branchstall = hif.branch_d &&
                      ((hif.regwrite_e && rd_e_hit) || (hif.memtoreg_m && rd_m_hit));
        mdstall     = (hif.md_op_d && (md_inflight || hif.md_start_e)) ||
                      (hif.md_start_e && rd_e_hit) ||
                      (md_inflight && md_dest_hit);
        stall       = lwstall || branchstall || mdstall;
    end

    // An issue while an operation is still in flight is dropped; an issue in
    // the md_done cycle reloads directly so md_busy never drops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_dest_d = md_dest_q;
        case (state_q)
            MD_IDLE: begin
                if (hif.md_start_e) begin
                    state_d   = MD_BUSY;
                    cnt_d     = MD_RELOAD;
                    md_dest_d = hif.writereg_e;
                end
            end
            MD_BUSY: begin
                if (md_done) begin
                    if (hif.md_start_e) begin
                        cnt_d     = MD_RELOAD;
                        md_dest_d = hif.writereg_e;
                    end else begin
                        state_d = MD_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hif.stall_cnt_clr)
            stall_cnt_d = '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_comb begin
        hif.stall_d   = stall;
        hif.stall_f   = stall;
        hif.flush_e   = stall;
        hif.md_busy   = (state_q == MD_BUSY);
        hif.md_done   = md_done;
        hif.md_dest   = md_dest_q;
        hif.stall_cnt = stall_cnt_q;
    end
endmodule

// File: tb/tb_hazard_unit_md.sv
// Bench for hazard_unit_md: directed scenarios then random traffic, checked
// against a cycle-indexed reference model through an expected-output queue.
module tb_hazard_unit_md;
    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic              fad;
        logic              fbd;
        logic [1:0]        fae;
        logic [1:0]        fbe;
        logic              sf;
        logic              sd;
        logic              fe;
        logic              busy;
        logic              done;
        logic [REG_AW-1:0] dest;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    logic clk;
    logic reset;
    hazard_unit_md_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

    hazard_unit_md #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: MDU tracked by the cycle number at which it completes
    int                m_cyc;
    bit                m_active;
    int                m_end;
    logic [REG_AW-1:0] m_dest;
    int                m_count;

    function automatic bit reads(input logic [REG_AW-1:0] r);
        return (r != 0) && (r == hif.rs_d || r == hif.rt_d);
    endfunction

    function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src);
        if (src != 0 && hif.regwrite_m && src == hif.writereg_m) return 2'b10;
        if (src != 0 && hif.regwrite_w && src == hif.writereg_w) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        hif.rs_d = 0; hif.rt_d = 0; hif.rs_e = 0; hif.rt_e = 0;
        hif.writereg_e = 0; hif.writereg_m = 0; hif.writereg_w = 0;
        hif.memtoreg_e = 0; hif.memtoreg_m = 0;
        hif.regwrite_e = 0; hif.regwrite_m = 0; hif.regwrite_w = 0;
        hif.branch_d = 0; hif.md_op_d = 0; hif.md_start_e = 0;
        hif.stall_cnt_clr = 0;
    endtask

    // driver: inputs already applied; predict this cycle, then advance model
    task automatic step();
        exp_t e;
        bit   done, inflight, lw, br, md, st;
        done     = m_active && (m_cyc == m_end);
        inflight = m_active && !done;
        lw = hif.memtoreg_e && reads(hif.rt_e);
        br = hif.branch_d && ((hif.regwrite_e && reads(hif.writereg_e)) ||
                              (hif.memtoreg_m && reads(hif.writereg_m)));
        md = (hif.md_op_d && (inflight || hif.md_start_e)) ||
             (hif.md_start_e && reads(hif.writereg_e)) ||
             (inflight && reads(m_dest));
        st = lw || br || md;
        e.fad  = hif.rs_d != 0 && hif.regwrite_m && hif.rs_d == hif.writereg_m;
        e.fbd  = hif.rt_d != 0 && hif.regwrite_m && hif.rt_d == hif.writereg_m;
        e.fae  = fwd_e(hif.rs_e);
        e.fbe  = fwd_e(hif.rt_e);
        e.sf   = st;
        e.sd   = st;
        e.fe   = st;
        e.busy = m_active;
        e.done = done;
        e.dest = m_dest;
        e.cnt  = CNT_W'(m_count);
        exp_q.push_back(e);

        if (reset) begin
            m_active = 0;
            m_dest   = 0;
            m_count  = 0;
        end else begin
            if (hif.md_start_e && !inflight) begin
                m_active = 1;
                m_end    = m_cyc + MD_LAT;
                m_dest   = hif.writereg_e;
            end else if (done) begin
                m_active = 0;
            end
            if (hif.stall_cnt_clr) m_count = 0;
            else if (st && m_count < CNT_MAX) m_count = m_count + 1;
        end
        m_cyc = m_cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // scoreboard monitor: one expected entry per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("forwarda_d", int'(hif.forwarda_d), int'(e.fad));
            check("forwardb_d", int'(hif.forwardb_d), int'(e.fbd));
            check("forwarda_e", int'(hif.forwarda_e), int'(e.fae));
            check("forwardb_e", int'(hif.forwardb_e), int'(e.fbe));
            check("stall_f",    int'(hif.stall_f),    int'(e.sf));
            check("stall_d",    int'(hif.stall_d),    int'(e.sd));
            check("flush_e",    int'(hif.flush_e),    int'(e.fe));
            check("md_busy",    int'(hif.md_busy),    int'(e.busy));
            check("md_done",    int'(hif.md_done),    int'(e.done));
            check("md_dest",    int'(hif.md_dest),    int'(e.dest));
            check("stall_cnt",  int'(hif.stall_cnt),  int'(e.cnt));
        end
    end

    task automatic issue_md(input logic [REG_AW-1:0] dst);
        clear_inputs();
        hif.md_start_e = 1; hif.writereg_e = dst;
        step();
        clear_inputs();
    endtask

    initial begin
        m_cyc = 0; m_active = 0; m_end = 0; m_dest = 0; m_count = 0;
        clear_inputs();
        reset = 1;
        @(posedge clk); @(posedge clk); #1;
        step();                     // reset state with all inputs zero
        reset = 0;

        // load-use
        hif.memtoreg_e = 1; hif.rt_e = 8; hif.rs_d = 8; step();
        hif.rt_e = 0; step();
        clear_inputs();

        // E forwarding priority
        hif.rs_e = 3; hif.writereg_m = 3; hif.writereg_w = 3;
        hif.regwrite_m = 1; hif.regwrite_w = 1; step();
        hif.regwrite_m = 0; step();
        hif.rs_e = 0; step();
        clear_inputs();

        // MDU latency with a dependent reader
        issue_md(9);
        for (int i = 0; i < MD_LAT; i++) begin hif.rs_d = 9; step(); end
        clear_inputs(); step();

        // back-to-back issue in the done cycle
        issue_md(5);
        for (int i = 0; i < MD_LAT - 1; i++) begin hif.md_op_d = 1; step(); end
        hif.md_op_d = 1; hif.md_start_e = 1; hif.writereg_e = 6; step();
        clear_inputs();
        for (int i = 0; i < MD_LAT + 2; i++) step();

        // stall counter saturation and clear
        hif.stall_cnt_clr = 1; step(); hif.stall_cnt_clr = 0;
        hif.memtoreg_e = 1; hif.rt_e = 7; hif.rt_d = 7;
        for (int i = 0; i < 5; i++) step();
        clear_inputs(); hif.stall_cnt_clr = 1; step();
        hif.memtoreg_e = 1; hif.rt_e = 7; hif.rt_d = 7; step();
        clear_inputs(); step(); step();

        // reset in busy cycle 2
        issue_md(12);
        step();
        reset = 1; step(); reset = 0;
        for (int i = 0; i < MD_LAT + 2; i++) step();

        // random traffic on a small register range to force collisions
        for (int n = 0; n < 500; n++) begin
            hif.rs_d = REG_AW'($urandom_range(0, 3));
            hif.rt_d = REG_AW'($urandom_range(0, 3));
            hif.rs_e = REG_AW'($urandom_range(0, 3));
            hif.rt_e = REG_AW'($urandom_range(0, 3));
            hif.writereg_e = REG_AW'($urandom_range(0, 3));
            hif.writereg_m = REG_AW'($urandom_range(0, 3));
            hif.writereg_w = REG_AW'($urandom_range(0, 3));
            hif.memtoreg_e = 1'($urandom_range(0, 3) == 0);
            hif.memtoreg_m = 1'($urandom_range(0, 3) == 0);
            hif.regwrite_e = 1'($urandom_range(0, 1));
            hif.regwrite_m = 1'($urandom_range(0, 1));
            hif.regwrite_w = 1'($urandom_range(0, 1));
            hif.branch_d   = 1'($urandom_range(0, 3) == 0);
            hif.md_op_d    = 1'($urandom_range(0, 3) == 0);
            hif.md_start_e = 1'($urandom_range(0, 3) == 0);
            hif.stall_cnt_clr = 1'($urandom_range(0, 15) == 0);
            reset = 1'($urandom_range(0, 63) == 0);
            step();
        end
        reset = 0;
        clear_inputs();
        step();

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
